// File: rtl/junction_controller.sv
// Two-road junction sequencer with pedestrian walk phase.
// Road A and road B alternate through red+amber, green and amber, with an
// all-red clearance between every change of right-of-way. A latched
// pedestrian request turns a clearance window into a walk phase before the
// next road is released. Aspects are a Moore decode of the state register.
module junction_controller #(
  parameter int T_RED_AMBER = 2,
  parameter int T_GREEN     = 8,
  parameter int T_AMBER     = 3,
  parameter int T_CLEAR     = 2,
  parameter int T_WALK      = 6,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  output logic       a_red,
  output logic       a_amber,
  output logic       a_green,
  output logic       b_red,
  output logic       b_amber,
  output logic       b_green,
  output logic       walk,
  output logic       ped_wait,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    RST_CLR = 4'd0,
    A_RA    = 4'd1,
    A_G     = 4'd2,
    A_AM    = 4'd3,
    CLR_AB  = 4'd4,
    B_RA    = 4'd5,
    B_G     = 4'd6,
    B_AM    = 4'd7,
    CLR_BA  = 4'd8,
    WALK    = 4'd9
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic             ped_pend;
  logic             next_is_b;
  logic             illegal;
  logic             advance;
  logic             pend_eff;
  logic             enter_walk;

  // Reload value for the phase timer on entry to a state (dwell minus one).
  function automatic logic [CNT_W-1:0] dwell(input state_t s);
    case (s)
      A_RA, B_RA: dwell = CNT_W'(T_RED_AMBER - 1);
      A_G,  B_G:  dwell = CNT_W'(T_GREEN - 1);
      A_AM, B_AM: dwell = CNT_W'(T_AMBER - 1);
      WALK:       dwell = CNT_W'(T_WALK - 1);
      default:    dwell = CNT_W'(T_CLEAR - 1);
    endcase
  endfunction

  // A request sampled on the final clearance edge still claims that window.
  assign pend_eff   = ped_pend | ped_req;
  assign advance    = illegal | (timer == '0);
  assign enter_walk = advance & (state_nxt == WALK);

  // Successor state; illegal codes fall back to the reset clearance at once.
  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    case (state)
      RST_CLR: state_nxt = A_RA;
      A_RA:    state_nxt = A_G;
      A_G:     state_nxt = A_AM;
      A_AM:    state_nxt = CLR_AB;
      CLR_AB:  state_nxt = pend_eff ? WALK : B_RA;
      B_RA:    state_nxt = B_G;
      B_G:     state_nxt = B_AM;
      B_AM:    state_nxt = CLR_BA;
      CLR_BA:  state_nxt = pend_eff ? WALK : A_RA;
      WALK:    state_nxt = next_is_b ? B_RA : A_RA;
      default: begin
        state_nxt = RST_CLR;
        illegal   = 1'b1;
      end
    endcase
  end

  // State register and phase timer: count down, move on when it reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_CLR;
      timer <= CNT_W'(T_CLEAR - 1);
    end else if (advance) begin
      state <= state_nxt;
      timer <= dwell(state_nxt);
    end else begin
      timer <= timer - CNT_W'(1);
    end
  end

  // Pedestrian latch and the record of which road is owed the next green.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend  <= 1'b0;
      next_is_b <= 1'b0;
    end else begin
      if (enter_walk)
        ped_pend <= 1'b0;
      else if (ped_req && state != WALK)
        ped_pend <= 1'b1;
      if (advance && state_nxt == CLR_AB)
        next_is_b <= 1'b1;
      else if (advance && state_nxt == CLR_BA)
        next_is_b <= 1'b0;
    end
  end

  // Aspect decode from the state register only; inactive road shows red.
  always_comb begin
    a_red   = 1'b1;
    a_amber = 1'b0;
    a_green = 1'b0;
    b_red   = 1'b1;
    b_amber = 1'b0;
    b_green = 1'b0;
    walk    = 1'b0;
    case (state)
      A_RA: a_amber = 1'b1;
      A_G:  begin a_red = 1'b0; a_green = 1'b1; end
      A_AM: begin a_red = 1'b0; a_amber = 1'b1; end
      B_RA: b_amber = 1'b1;
      B_G:  begin b_red = 1'b0; b_green = 1'b1; end
      B_AM: begin b_red = 1'b0; b_amber = 1'b1; end
      WALK: walk = 1'b1;
      default: ;
    endcase
  end

  assign ped_wait = ped_pend;
  assign phase    = state;

endmodule

// File: tb/tb_junction_controller.sv
// Scoreboard bench for junction_controller: a default-timed instance and a
// fast instance (single-cycle green, clear and walk) run side by side.
// Expected outputs come from a phase-table model of the junction rules.
module tb_junction_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_s = 1'b0;
  logic       req_f = 1'b0;

  logic       sa_r, sa_a, sa_g, sb_r, sb_a, sb_g, s_walk, s_wait;
  logic [3:0] s_ph;
  logic       fa_r, fa_a, fa_g, fb_r, fb_a, fb_g, f_walk, f_wait;
  logic [3:0] f_ph;

  logic [11:0] out_s, out_f;
  assign out_s = {s_ph, sa_r, sa_a, sa_g, sb_r, sb_a, sb_g, s_walk, s_wait};
  assign out_f = {f_ph, fa_r, fa_a, fa_g, fb_r, fb_a, fb_g, f_walk, f_wait};

  always #5 clk = ~clk;

  junction_controller u_slow (
    .clk(clk), .rst_n(rst_n), .ped_req(req_s),
    .a_red(sa_r), .a_amber(sa_a), .a_green(sa_g),
    .b_red(sb_r), .b_amber(sb_a), .b_green(sb_g),
    .walk(s_walk), .ped_wait(s_wait), .phase(s_ph)
  );

  junction_controller #(.T_GREEN(1), .T_CLEAR(1), .T_WALK(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .ped_req(req_f),
    .a_red(fa_r), .a_amber(fa_a), .a_green(fa_g),
    .b_red(fb_r), .b_amber(fb_a), .b_green(fb_g),
    .walk(f_walk), .ped_wait(f_wait), .phase(f_ph)
  );

  // Model: which phase is showing, how many cycles of it remain, the
  // pedestrian latch, and whether road B is owed the next green.
  typedef struct {
    int ph;
    int left;
    bit pend;
    bit nextb;
  } model_t;

  model_t      ms, mf;
  logic [11:0] q_s[$];
  logic [11:0] q_f[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int dur(input int ph, input bit fast);
    case (ph)
      1, 5:    return 2;
      2, 6:    return fast ? 1 : 8;
      3, 7:    return 3;
      9:       return fast ? 1 : 6;
      default: return fast ? 1 : 2;
    endcase
  endfunction

  function automatic model_t rst_model(input bit fast);
    model_t r;
    r.ph = 0; r.left = dur(0, fast); r.pend = 1'b0; r.nextb = 1'b0;
    return r;
  endfunction

  // Advance the model by one clock edge with pedestrian input req.
  function automatic model_t step(input model_t m, input bit req, input bit fast);
    model_t n = m;
    int nx;
    if (m.left == 1) begin
      case (m.ph)
        0: nx = 1;
        1: nx = 2;
        2: nx = 3;
        3: nx = 4;
        4: nx = (m.pend || req) ? 9 : 5;
        5: nx = 6;
        6: nx = 7;
        7: nx = 8;
        8: nx = (m.pend || req) ? 9 : 1;
        default: nx = m.nextb ? 5 : 1;
      endcase
      n.ph = nx;
      n.left = dur(nx, fast);
      if (nx == 4) n.nextb = 1'b1;
      if (nx == 8) n.nextb = 1'b0;
    end else begin
      n.left = m.left - 1;
    end
    if (n.ph == 9 && m.ph != 9) n.pend = 1'b0;
    else if (req && m.ph != 9)  n.pend = 1'b1;
    return n;
  endfunction

  // Expected output word: {phase, a_r,a_a,a_g, b_r,b_a,b_g, walk, ped_wait}.
  function automatic logic [11:0] expect_out(input model_t m);
    logic [3:0] p;
    logic ar, aa, ag, br, ba, bg;
    p  = 4'(m.ph);
    ar = !(m.ph == 2 || m.ph == 3);
    aa = (m.ph == 1 || m.ph == 3);
    ag = (m.ph == 2);
    br = !(m.ph == 6 || m.ph == 7);
    ba = (m.ph == 5 || m.ph == 7);
    bg = (m.ph == 6);
    return {p, ar, aa, ag, br, ba, bg, (m.ph == 9), m.pend};
  endfunction

  task automatic cmp(input string name, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit safe(input logic [11:0] o);
    bit a_go, b_go, ok;
    a_go = o[6] | o[5];
    b_go = o[3] | o[2];
    ok = !(a_go && b_go);
    if (o[1]) ok = ok && o[7] && o[4] && !a_go && !b_go;
    return ok;
  endfunction

  // One clock of stimulus: drive inputs, advance models, queue expectations.
  task automatic tick(input bit rst_v, input bit r_s);
    @(negedge clk);
    rst_n = rst_v;
    req_s = r_s;
    req_f = ($urandom_range(0, 3) == 0);
    if (!rst_v) begin
      ms = rst_model(1'b0);
      mf = rst_model(1'b1);
    end else begin
      ms = step(ms, r_s, 1'b0);
      mf = step(mf, req_f, 1'b1);
    end
    q_s.push_back(expect_out(ms));
    q_f.push_back(expect_out(mf));
  endtask

  task automatic bound_fail(input string name, input int guard, input int limit);
    if (guard >= limit) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: waited %0d cycles, required under %0d", name, guard, limit);
    end
  endtask

  // Monitor: compare each presented output word against the queued expectation.
  always begin
    @(posedge clk);
    #1;
    if (q_s.size() > 0) cmp("slow_out", out_s, q_s.pop_front());
    if (q_f.size() > 0) cmp("fast_out", out_f, q_f.pop_front());
    cmp("slow_safety", {11'd0, safe(out_s)}, 12'd1);
    cmp("fast_safety", {11'd0, safe(out_f)}, 12'd1);
  end

  initial begin
    int guard;
    ms = rst_model(1'b0);
    mf = rst_model(1'b1);

    // Held in reset, then free-running with no pedestrians for over two periods.
    repeat (3) tick(1'b0, 1'b0);
    repeat (70) tick(1'b1, 1'b0);

    // Single-cycle pulse during A green.
    guard = 0;
    while (ms.ph != 2 && guard < 100) begin tick(1'b1, 1'b0); guard++; end
    bound_fail("wait_a_green", guard, 100);
    tick(1'b1, 1'b1);
    repeat (40) tick(1'b1, 1'b0);

    // Request held high from A amber through the walk phase and beyond.
    guard = 0;
    while (ms.ph != 3 && guard < 100) begin tick(1'b1, 1'b0); guard++; end
    bound_fail("wait_a_amber", guard, 100);
    repeat (25) tick(1'b1, 1'b1);
    repeat (45) tick(1'b1, 1'b0);

    // Request arriving exactly on the final edge of CLR_BA.
    guard = 0;
    while (!(ms.ph == 8 && ms.left == 1 && !ms.pend) && guard < 100) begin
      tick(1'b1, 1'b0); guard++;
    end
    bound_fail("wait_clr_ba_end", guard, 100);
    tick(1'b1, 1'b1);
    repeat (20) tick(1'b1, 1'b0);

    // Latch a request in B green, then pulse reset mid-cycle.
    guard = 0;
    while (ms.ph != 6 && guard < 100) begin tick(1'b1, 1'b0); guard++; end
    bound_fail("wait_b_green", guard, 100);
    tick(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_slow", out_s, expect_out(rst_model(1'b0)));
    cmp("async_rst_fast", out_f, expect_out(rst_model(1'b1)));
    void'(q_s.pop_back());
    void'(q_f.pop_back());
    ms = rst_model(1'b0);
    mf = rst_model(1'b1);
    q_s.push_back(expect_out(ms));
    q_f.push_back(expect_out(mf));
    repeat (2) tick(1'b0, 1'b0);
    repeat (40) tick(1'b1, 1'b0);

    // Random pedestrian traffic.
    repeat (300) tick(1'b1, $urandom_range(0, 11) == 0);
    repeat (5) tick(1'b1, 1'b0);

    guard = 0;
    while ((q_s.size() > 0 || q_f.size() > 0) && guard < 20) begin
      @(posedge clk); guard++;
    end
    bound_fail("drain", guard, 20);
    #10;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
